// File: rtl/tempsens_conv_ctrl.sv
// ---------------------------------------------------------------------------
// tempsens_conv_ctrl
//
// Conversion sequencer for the switched-cap temperature sensor that hangs off
// the bandgap core. On a host start pulse it waits for the bandgap to settle,
// resets the integration cap, ramps the cap with the PTAT current while it is
// compared against the reference, and counts ramp cycles until the comparator
// trips. 2^AVG_LOG2 such samples are averaged and returned through a
// valid/ack handshake. The bandgap loop itself lives in its own controller;
// this block only drives the analog switch controls.
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-high reset
//   start         single-cycle conversion request (ignored unless idle)
//   bg_valid      bandgap settled indication; dropping it mid-measurement
//                 restarts the whole measurement
//   cmp           raw asynchronous comparator output
//   result_ack    host has consumed the result
//   busy          high from accepted start until the result is published
//   s_CapRst      integration cap reset switch
//   s_Cap2CMP     cap-to-comparator switch
//   s_Ref2CMP     reference-to-comparator switch
//   s_PtatOut     PTAT current onto the cap
//   result        averaged ramp count (held until the next conversion ends)
//   result_valid  result available, held until acknowledged
//   ovf           at least one sample of this result hit the counter ceiling
// ---------------------------------------------------------------------------
module tempsens_conv_ctrl #(
  parameter int CNT_W      = 10,
  parameter int SETTLE_CYC = 8,
  parameter int RST_CYC    = 4,
  parameter int AVG_LOG2   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             bg_valid,
  input  logic             cmp,
  input  logic             result_ack,
  output logic             busy,
  output logic             s_CapRst,
  output logic             s_Cap2CMP,
  output logic             s_Ref2CMP,
  output logic             s_PtatOut,
  output logic [CNT_W-1:0] result,
  output logic             result_valid,
  output logic             ovf
);

  localparam int SUM_W = CNT_W + AVG_LOG2;
  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int RST_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  localparam logic [CNT_W-1:0]    CNT_MAX     = '1;
  localparam logic [SET_W-1:0]    SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [RST_W-1:0]    RST_LAST    = RST_W'(RST_CYC - 1);
  localparam logic [AVG_LOG2-1:0] IDX_LAST    = '1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_BG = 3'd1,
    CAPRST  = 3'd2,
    RAMP    = 3'd3,
    ACCUM   = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t              state;
  logic                cmp_meta;
  logic                cmp_s;
  logic [SET_W-1:0]    settle_cnt;
  logic [RST_W-1:0]    rst_cnt;
  logic [CNT_W-1:0]    ramp_cnt;
  logic [CNT_W-1:0]    sample;
  logic [SUM_W-1:0]    sum;
  logic [AVG_LOG2-1:0] idx;
  logic                abort;

  // Losing the bandgap while the cap is being reset, ramped or accumulated
  // invalidates the measurement, so every such phase restarts from settling.
  assign abort = !bg_valid && (state == CAPRST || state == RAMP || state == ACCUM);

  // Two-flop synchroniser for the comparator; it runs every cycle so the
  // ramp logic always sees a clean, two-cycle-delayed copy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmp_meta <= 1'b0;
      cmp_s    <= 1'b0;
    end else begin
      cmp_meta <= cmp;
      cmp_s    <= cmp_meta;
    end
  end

  // Conversion sequencer. Switch controls are registered and are only ever
  // raised on the transition into their phase, so the cap reset switch and
  // the ramp switches can never be closed in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      s_CapRst     <= 1'b0;
      s_Cap2CMP    <= 1'b0;
      s_Ref2CMP    <= 1'b0;
      s_PtatOut    <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      ovf          <= 1'b0;
      settle_cnt   <= '0;
      rst_cnt      <= '0;
      ramp_cnt     <= '0;
      sample       <= '0;
      sum          <= '0;
      idx          <= '0;
    end else begin
      if (result_ack && result_valid) begin
        result_valid <= 1'b0;
      end

      if (abort) begin
        state      <= WAIT_BG;
        s_CapRst   <= 1'b0;
        s_Cap2CMP  <= 1'b0;
        s_Ref2CMP  <= 1'b0;
        s_PtatOut  <= 1'b0;
        sum        <= '0;
        idx        <= '0;
        ovf        <= 1'b0;
        settle_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state        <= WAIT_BG;
              busy         <= 1'b1;
              result_valid <= 1'b0;
              ovf          <= 1'b0;
              sum          <= '0;
              idx          <= '0;
              settle_cnt   <= '0;
            end
          end

          WAIT_BG: begin
            if (!bg_valid) begin
              settle_cnt <= '0;
            end else if (settle_cnt == SETTLE_LAST) begin
              state    <= CAPRST;
              s_CapRst <= 1'b1;
              rst_cnt  <= '0;
            end else begin
              settle_cnt <= settle_cnt + SET_W'(1);
            end
          end

          CAPRST: begin
            ramp_cnt <= '0;
            if (rst_cnt == RST_LAST) begin
              state     <= RAMP;
              s_CapRst  <= 1'b0;
              s_Cap2CMP <= 1'b1;
              s_Ref2CMP <= 1'b1;
              s_PtatOut <= 1'b1;
            end else begin
              rst_cnt <= rst_cnt + RST_W'(1);
            end
          end

          // A comparator trip wins over the ceiling, so a trip exactly at
          // the ceiling is a legal sample and does not flag overflow.
          RAMP: begin
            if (cmp_s || ramp_cnt == CNT_MAX) begin
              state     <= ACCUM;
              sample    <= ramp_cnt;
              s_Cap2CMP <= 1'b0;
              s_Ref2CMP <= 1'b0;
              s_PtatOut <= 1'b0;
              if (!cmp_s) begin
                ovf <= 1'b1;
              end
            end else begin
              ramp_cnt <= ramp_cnt + CNT_W'(1);
            end
          end

          // The sum is wide enough for 2^AVG_LOG2 full-scale samples.
          ACCUM: begin
            sum <= sum + SUM_W'(sample);
            if (idx == IDX_LAST) begin
              state <= DONE;
            end else begin
              idx      <= idx + AVG_LOG2'(1);
              state    <= CAPRST;
              s_CapRst <= 1'b1;
              rst_cnt  <= '0;
            end
          end

          DONE: begin
            result       <= CNT_W'(sum >> AVG_LOG2);
            result_valid <= 1'b1;
            busy         <= 1'b0;
            state        <= IDLE;
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tempsens_conv_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tempsens_conv_ctrl
//
// Bench for tempsens_conv_ctrl. Each conversion is planned as a timeline of
// cycles: the planner lays out the phases (settling, cap reset, ramp,
// accumulate, publish) as segments whose lengths follow from the chosen
// comparator trip points, and records per cycle both the inputs to drive and
// the outputs the block must show. A driver plays the timeline and a compare
// process checks every cycle against it. A few literal expectations pin the
// planner itself.
// ---------------------------------------------------------------------------
module tb_tempsens_conv_ctrl;

  localparam int CNT_W    = 10;
  localparam int SETTLE   = 8;
  localparam int RSTC     = 4;
  localparam int AVG_LOG2 = 2;
  localparam int NSAMP    = 1 << AVG_LOG2;
  localparam int CMAX     = (1 << CNT_W) - 1;
  localparam int NEVER    = 100000;

  typedef int samp_arr_t [NSAMP];

  typedef struct {
    logic start;
    logic bg;
    logic cmp;
    logic ack;
    logic busy;
    logic cap_rst;
    logic ramp;
    logic rv;
    logic ovf;
    int   res;
  } cyc_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             bg_valid;
  logic             cmp;
  logic             result_ack;
  logic             busy;
  logic             s_CapRst;
  logic             s_Cap2CMP;
  logic             s_Ref2CMP;
  logic             s_PtatOut;
  logic [CNT_W-1:0] result;
  logic             result_valid;
  logic             ovf;

  tempsens_conv_ctrl #(
    .CNT_W      (CNT_W),
    .SETTLE_CYC (SETTLE),
    .RST_CYC    (RSTC),
    .AVG_LOG2   (AVG_LOG2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .bg_valid     (bg_valid),
    .cmp          (cmp),
    .result_ack   (result_ack),
    .busy         (busy),
    .s_CapRst     (s_CapRst),
    .s_Cap2CMP    (s_Cap2CMP),
    .s_Ref2CMP    (s_Ref2CMP),
    .s_PtatOut    (s_PtatOut),
    .result       (result),
    .result_valid (result_valid),
    .ovf          (ovf)
  );

  always #5 clk = ~clk;

  cyc_t plan[$];
  cyc_t cur_exp;
  logic check_en = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;

  // Outputs the block must show in the next planned cycle.
  logic m_busy, m_cap_rst, m_ramp, m_rv, m_ovf;
  int   m_res;

  // Observations from the most recent playback.
  int busy_cycles, t_busy_rise, t_cap_rise, t_cap_fall, t_ramp_rise;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      if (tests_failed <= 40)
        $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic rbit();
    return $urandom_range(0, 1) == 1;
  endfunction

  task automatic push(input logic st, input logic bg, input logic c, input logic ack);
    cyc_t e;
    e.start   = st;
    e.bg      = bg;
    e.cmp     = c;
    e.ack     = ack;
    e.busy    = m_busy;
    e.cap_rst = m_cap_rst;
    e.ramp    = m_ramp;
    e.rv      = m_rv;
    e.ovf     = m_ovf;
    e.res     = m_res;
    plan.push_back(e);
  endtask

  task automatic planIdle(input int n, input logic allow_ack);
    for (int i = 0; i < n; i++) begin
      logic a;
      a = allow_ack ? rbit() : 1'b0;
      push(1'b0, rbit(), rbit(), a);
      if (a) m_rv = 1'b0;
    end
  endtask

  task automatic planAck();
    push(1'b0, 1'b1, 1'b0, 1'b0);
    push(1'b0, 1'b1, 1'b0, 1'b1);
    m_rv = 1'b0;
    push(1'b0, 1'b1, 1'b0, 1'b0);
    push(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // Settling: some interrupted runs of bg_valid, then SETTLE good cycles.
  task automatic planSettle(input int breaks);
    for (int b = 0; b < breaks; b++) begin
      int n;
      n = $urandom_range(0, SETTLE - 1);
      for (int i = 0; i < n; i++) push(rbit(), 1'b1, rbit(), rbit());
      push(rbit(), 1'b0, rbit(), rbit());
    end
    for (int i = 0; i < SETTLE; i++) push(rbit(), 1'b1, rbit(), rbit());
  endtask

  // r[k] is the ramp-relative cycle in which raw cmp is first high for
  // sample k (negative values reach back into the cap reset phase). The
  // two-flop synchroniser makes the sample r+2, clipped at the ceiling.
  // One optional abort: bg_valid low at cycle abort_pos of sample abort_samp;
  // samples before the abort use shifted trip points so a stale sum shows.
  task automatic planConversion(input samp_arr_t r, input int abort_samp,
                                input int abort_pos, input int breaks);
    int   sum;
    int   k;
    logic abort_done;
    push(1'b1, rbit(), rbit(), rbit());
    m_busy = 1'b1;
    m_rv   = 1'b0;
    m_ovf  = 1'b0;
    sum = 0;
    k = 0;
    abort_done = (abort_samp < 0);
    planSettle(breaks);
    while (k < NSAMP) begin
      int   rr;
      int   samp;
      logic hit;
      rr   = abort_done ? r[k] : r[k] + 37;
      samp = (rr + 2 > CMAX) ? CMAX : rr + 2;
      hit  = 1'b0;
      m_cap_rst = 1'b1;
      for (int p = 0; p < RSTC + samp + 2; p++) begin
        logic c_in;
        c_in = (p >= RSTC + rr) && (p < RSTC + samp + 1);
        if (!abort_done && k == abort_samp && p == abort_pos) begin
          push(rbit(), 1'b0, c_in, rbit());
          hit = 1'b1;
          break;
        end
        push(rbit(), 1'b1, c_in, rbit());
        if (p == RSTC - 1) begin
          m_cap_rst = 1'b0;
          m_ramp    = 1'b1;
        end else if (p == RSTC + samp) begin
          m_ramp = 1'b0;
          if (rr + 2 > CMAX) m_ovf = 1'b1;
        end
      end
      if (hit) begin
        m_cap_rst  = 1'b0;
        m_ramp     = 1'b0;
        m_ovf      = 1'b0;
        sum        = 0;
        k          = 0;
        abort_done = 1'b1;
        planSettle(0);
      end else begin
        sum += samp;
        k++;
      end
    end
    push(rbit(), rbit(), 1'b0, rbit());
    m_busy = 1'b0;
    m_rv   = 1'b1;
    m_res  = sum / NSAMP;
  endtask

  // Plays the planned cycles (all of them when limit < 0) and empties the plan.
  task automatic applyStimulus(input int limit);
    int n;
    n = (limit < 0 || limit > plan.size()) ? plan.size() : limit;
    busy_cycles = 0;
    t_busy_rise = -1;
    t_cap_rise  = -1;
    t_cap_fall  = -1;
    t_ramp_rise = -1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      start      = plan[i].start;
      bg_valid   = plan[i].bg;
      cmp        = plan[i].cmp;
      result_ack = plan[i].ack;
      cur_exp    = plan[i];
      check_en   = 1'b1;
      if (busy) busy_cycles++;
      if (busy && t_busy_rise < 0) t_busy_rise = i;
      if (s_CapRst && t_cap_rise < 0) t_cap_rise = i;
      if (!s_CapRst && t_cap_rise >= 0 && t_cap_fall < 0) t_cap_fall = i;
      if (s_Cap2CMP && s_Ref2CMP && s_PtatOut && t_ramp_rise < 0) t_ramp_rise = i;
    end
    @(negedge clk);
    #1;
    check_en = 1'b0;
    plan.delete();
  endtask

  // Compare process: every played cycle, outputs against the timeline.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("busy", busy, cur_exp.busy);
      checkOutput("s_CapRst", s_CapRst, cur_exp.cap_rst);
      checkOutput("s_Cap2CMP", s_Cap2CMP, cur_exp.ramp);
      checkOutput("s_Ref2CMP", s_Ref2CMP, cur_exp.ramp);
      checkOutput("s_PtatOut", s_PtatOut, cur_exp.ramp);
      checkOutput("result_valid", result_valid, cur_exp.rv);
      checkOutput("ovf", ovf, cur_exp.ovf);
      checkOutput("result", result, cur_exp.res);
      checkOutput("switch overlap", s_CapRst & (s_Cap2CMP | s_Ref2CMP | s_PtatOut), 0);
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #(60000 * 10);
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    samp_arr_t r;
    reset = 1'b1;
    start = 1'b0;
    bg_valid = 1'b0;
    cmp = 1'b0;
    result_ack = 1'b0;
    m_busy = 1'b0;
    m_cap_rst = 1'b0;
    m_ramp = 1'b0;
    m_rv = 1'b0;
    m_ovf = 1'b0;
    m_res = 0;

    // Reset state.
    repeat (2) @(negedge clk);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset switches", {s_CapRst, s_Cap2CMP, s_Ref2CMP, s_PtatOut}, 0);
    checkOutput("reset result_valid", result_valid, 0);
    checkOutput("reset ovf", ovf, 0);
    checkOutput("reset result", result, 0);
    #1 reset = 1'b0;

    // Sequencing timeline and a steady trip point.
    r = '{100, 100, 100, 100};
    planConversion(r, -1, 0, 0);
    planIdle(2, 1'b0);
    applyStimulus(-1);
    checkOutput("cap reset delay after busy", t_cap_rise - t_busy_rise, 8);
    checkOutput("cap reset width", t_cap_fall - t_cap_rise, 4);
    checkOutput("ramp start after cap reset", t_ramp_rise - t_cap_rise, 4);
    checkOutput("steady result", result, 102);
    checkOutput("steady result_valid", result_valid, 1);
    checkOutput("steady ovf", ovf, 0);

    // Spread trip points, truncating average, then acknowledge.
    r = '{98, 99, 100, 101};
    planConversion(r, -1, 0, 0);
    planIdle(1, 1'b0);
    applyStimulus(-1);
    checkOutput("spread result", result, 101);
    checkOutput("spread result_valid", result_valid, 1);
    planAck();
    applyStimulus(-1);
    checkOutput("ack result_valid", result_valid, 0);
    checkOutput("ack result held", result, 101);

    // Comparator never trips: every sample hits the ceiling.
    r = '{NEVER, NEVER, NEVER, NEVER};
    planConversion(r, -1, 0, 0);
    planIdle(2, 1'b0);
    applyStimulus(-1);
    checkOutput("ceiling result", result, 1023);
    checkOutput("ceiling ovf", ovf, 1);
    checkOutput("ceiling busy span", busy_cycles + 1, 1 + 8 + 4 * (4 + 1024 + 1) + 1);

    // Trip exactly at the ceiling is a real sample, not an overflow.
    r = '{1021, 5, 5, 5};
    planConversion(r, -1, 0, 0);
    planIdle(2, 1'b0);
    applyStimulus(-1);
    checkOutput("edge ceiling result", result, 261);
    checkOutput("edge ceiling ovf", ovf, 0);

    // Bandgap drop in the third ramp restarts the measurement.
    r = '{10, 20, 30, 40};
    planConversion(r, 2, RSTC + 10, 0);
    planIdle(2, 1'b0);
    applyStimulus(-1);
    checkOutput("abort result", result, 27);
    checkOutput("abort ovf", ovf, 0);

    // Randomised conversions.
    for (int t = 0; t < 16; t++) begin
      int a_s, a_p, brk;
      for (int k = 0; k < NSAMP; k++)
        r[k] = ($urandom_range(0, 9) == 0) ? -2 + int'($urandom_range(0, 1))
                                           : int'($urandom_range(0, 60));
      brk = $urandom_range(0, 2);
      a_s = -1;
      a_p = 0;
      if ($urandom_range(0, 2) == 0) begin
        a_s = $urandom_range(0, NSAMP - 1);
        a_p = $urandom_range(0, RSTC + r[a_s] + 37 + 2 + 1);
      end
      planConversion(r, a_s, a_p, brk);
      planIdle($urandom_range(1, 6), 1'b1);
      applyStimulus(-1);
    end

    // Reset in the middle of a ramp.
    r = '{500, 500, 500, 500};
    planConversion(r, -1, 0, 0);
    applyStimulus(1 + SETTLE + RSTC + 50);
    checkOutput("pre-reset ramp", s_PtatOut, 1);
    reset = 1'b1;
    #1;
    checkOutput("mid-ramp reset busy", busy, 0);
    checkOutput("mid-ramp reset switches", {s_CapRst, s_Cap2CMP, s_Ref2CMP, s_PtatOut}, 0);
    checkOutput("mid-ramp reset result_valid", result_valid, 0);
    start = 1'b0;
    result_ack = 1'b0;
    #1 reset = 1'b0;
    m_busy = 1'b0;
    m_cap_rst = 1'b0;
    m_ramp = 1'b0;
    m_rv = 1'b0;
    m_ovf = 1'b0;
    m_res = 0;

    // Recovery after reset.
    r = '{3, 7, 11, 15};
    planIdle(2, 1'b1);
    planConversion(r, -1, 0, 1);
    planIdle(2, 1'b0);
    applyStimulus(-1);
    checkOutput("post-reset result", result, 11);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
